// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone classic arbiter: N masters share one slave port.
// The grant is locked for the whole cyc; a per-beat watchdog errors out stuck strobes.
module wb_arbiter_rr #(
  parameter int N_MASTERS = 2,
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_MASTERS*ADR_WIDTH-1:0] m_adr_i,
  input  logic [N_MASTERS*DAT_WIDTH-1:0] m_dat_i,
  input  logic [N_MASTERS-1:0]           m_we_i,
  input  logic [N_MASTERS-1:0]           m_cyc_i,
  input  logic [N_MASTERS-1:0]           m_stb_i,
  output logic [DAT_WIDTH-1:0]           m_dat_o,
  output logic [N_MASTERS-1:0]           m_ack_o,
  output logic [N_MASTERS-1:0]           m_err_o,
  output logic [ADR_WIDTH-1:0]           s_adr_o,
  output logic [DAT_WIDTH-1:0]           s_dat_o,
  output logic                           s_we_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  input  logic [DAT_WIDTH-1:0]           s_dat_i,
  input  logic                           s_ack_i,
  output logic [N_MASTERS-1:0]           gnt_o
);

  // Handshake: a beat completes in the cycle where the owner's stb and the
  // slave's ack are both high; cyc frames the whole (possibly multi-beat) cycle.

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MASTERS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  int unsigned          cand;
  logic [IDX_W-1:0]     cand_idx;

  logic [ADR_WIDTH-1:0] adr_arr [N_MASTERS];
  logic [DAT_WIDTH-1:0] dat_arr [N_MASTERS];
  logic                 own_cyc, own_stb;

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
    assign adr_arr[k] = m_adr_i[k*ADR_WIDTH +: ADR_WIDTH];
    assign dat_arr[k] = m_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
  end

  // last_q doubles as the owner index while a grant is held.
  assign own_cyc = m_cyc_i[last_q];
  assign own_stb = m_stb_i[last_q];
  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;

  // First requester after the last granted master, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      cand     = (int'(last_q) + i) % N_MASTERS;
      cand_idx = cand[IDX_W-1:0];
      if (!pick_valid && m_cyc_i[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    s_adr_o = '0;
    s_dat_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          state_d         = GRANT;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          last_d          = pick_idx;
        end
      end

      GRANT: begin
        s_adr_o         = adr_arr[last_q];
        s_dat_o         = dat_arr[last_q];
        s_we_o          = m_we_i[last_q];
        s_cyc_o         = own_cyc;
        s_stb_o         = own_stb;
        m_ack_o[last_q] = s_ack_i;

        if (TIMEOUT > 0) begin
          if (!own_stb || s_ack_i) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_MAX) begin
            // A late ack in this same cycle takes the branch above instead.
            m_err_o[last_q] = 1'b1;
            cnt_d           = '0;
            state_d         = FLUSH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        if (!own_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end

      FLUSH: begin
        // Slave side stays quiet until the errored master releases cyc.
        cnt_d = '0;
        if (!own_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr (3 masters, watchdog of 4): grant order is scoreboarded,
// bus muxing, ack/err routing, watchdog timing and async reset are checked directly.
module tb_wb_arbiter_rr;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*AW-1:0] m_adr_i = '0;
  logic [N*DW-1:0] m_dat_i = '0;
  logic [N-1:0]    m_we_i  = '0;
  logic [N-1:0]    m_cyc_i = '0;
  logic [N-1:0]    m_stb_i = '0;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o;
  logic [N-1:0]    m_err_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic            s_we_o;
  logic            s_cyc_o;
  logic            s_stb_o;
  logic [DW-1:0]   s_dat_i = '0;
  logic            s_ack_i;
  logic [N-1:0]    gnt_o;

  logic            auto_ack = 1'b0;
  logic            man_ack  = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] mon_exp;

  // Auto mode models a slave that acks every strobe immediately.
  assign s_ack_i = auto_ack ? s_stb_o : man_ack;

  wb_arbiter_rr #(
    .N_MASTERS(N),
    .ADR_WIDTH(AW),
    .DAT_WIDTH(DW),
    .TIMEOUT  (TO)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i),
    .m_we_i (m_we_i),
    .m_cyc_i(m_cyc_i),
    .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o),
    .m_err_o(m_err_o),
    .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o),
    .s_we_o (s_we_o),
    .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i),
    .gnt_o  (gnt_o)
  );

  // clock / time limit
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL time_limit: got=running exp=finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc_i[k]         = cyc;
    m_stb_i[k]         = stb;
    m_we_i[k]          = we;
    m_adr_i[k*AW +: AW] = adr;
    m_dat_i[k*DW +: DW] = dat;
  endtask

  task automatic idle_all();
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = '0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    idle_all();
    man_ack  = 1'b0;
    auto_ack = 1'b0;
    repeat (2) @(posedge clk);
    smp();
    check("rst_gnt", gnt_o, 0);
    check("rst_cyc_stb_we", {s_cyc_o, s_stb_o, s_we_o}, 0);
    check("rst_adr_dat", {s_adr_o, s_dat_o}, 0);
    check("rst_ack_err", {m_ack_o, m_err_o}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Every listed master keeps requesting single read beats; after an ack it drops cyc for a cycle.
  task automatic run_auto(input int n, input logic [N-1:0] mask);
    logic [N-1:0] drop;
    drop     = '0;
    auto_ack = 1'b1;
    for (int c = 0; c < n; c++) begin
      drv();
      for (int k = 0; k < N; k++) begin
        if (mask[k]) set_m(k, !drop[k], !drop[k], 1'b0, 16'h0100 + AW'(k), '0);
      end
      smp();
      for (int k = 0; k < N; k++) begin
        if (gnt_o == N'(1 << k)) check("auto_adr", s_adr_o, 16'h0100 + k);
      end
      check("auto_no_err", m_err_o, 0);
      drop = m_ack_o & mask;
    end
    drv();
    idle_all();
    auto_ack = 1'b0;
    smp();
    drv();
    smp();
    check("auto_end_idle", gnt_o, 0);
  endtask

  // scoreboard: each new grant must match the next expected owner
  always @(negedge clk) begin
    if (gnt_o != '0 && prev_gnt == '0) begin
      if (exp_q.size() == 0) begin
        check("gnt_unexpected", gnt_o, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("gnt_order", gnt_o, mon_exp);
      end
    end
    prev_gnt <= gnt_o;
  end

  initial begin
    logic [DW-1:0] rd;

    // single write, slave acks two cycles after the strobe
    do_reset();
    drv();
    set_m(0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF);
    exp_q.push_back(3'b001);
    smp();
    check("t1_latency", gnt_o, 0);
    drv();
    smp();
    check("t1_gnt", gnt_o, 3'b001);
    check("t1_adr", s_adr_o, 16'h1234);
    check("t1_dat", s_dat_o, 16'hBEEF);
    check("t1_we_cyc_stb", {s_we_o, s_cyc_o, s_stb_o}, 3'b111);
    check("t1_noack_a", m_ack_o, 0);
    drv();
    smp();
    check("t1_noack_b", m_ack_o, 0);
    drv();
    man_ack = 1'b1;
    smp();
    check("t1_ack", m_ack_o, 3'b001);
    drv();
    man_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'hBEEF);
    smp();
    check("t1_ack_once", m_ack_o, 0);
    drv();
    smp();
    check("t1_release", gnt_o, 0);

    // two simultaneous requesters after reset
    do_reset();
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    run_auto(6, 3'b011);

    // three continuous requesters: no starvation
    do_reset();
    repeat (2) begin
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b100);
    end
    run_auto(18, 3'b111);

    // multi-beat lock: master0 reads three beats while master1 waits
    drv();
    set_m(0, 1'b1, 1'b1, 1'b0, 16'h2000, '0);
    set_m(1, 1'b1, 1'b1, 1'b0, 16'h3000, '0);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    smp();
    for (int b = 0; b < 3; b++) begin
      drv();
      set_m(0, 1'b1, 1'b1, 1'b0, 16'h2000 + AW'(b), '0);
      rd      = DW'($urandom_range(0, 16'hFFFF));
      s_dat_i = rd;
      man_ack = 1'b1;
      smp();
      check("t3_lock_gnt", gnt_o, 3'b001);
      check("t3_beat_ack", m_ack_o, 3'b001);
      check("t3_beat_adr", s_adr_o, 16'h2000 + b);
      check("t3_rdata", m_dat_o, rd);
    end
    drv();
    man_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 16'h2000, '0);
    smp();
    check("t3_drop_edge", gnt_o, 3'b001);
    drv();
    smp();
    check("t3_idle_gap", gnt_o, 0);
    drv();
    man_ack = 1'b1;
    smp();
    check("t3_m1_gnt", gnt_o, 3'b010);
    check("t3_m1_ack", m_ack_o, 3'b010);
    check("t3_m1_adr", s_adr_o, 16'h3000);
    drv();
    man_ack = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 16'h3000, '0);
    smp();
    drv();
    smp();
    check("t3_end_idle", gnt_o, 0);

    // watchdog fires on the fifth unacked strobe cycle
    drv();
    set_m(1, 1'b1, 1'b1, 1'b1, 16'h4000, 16'h5555);
    exp_q.push_back(3'b010);
    smp();
    for (int s = 1; s <= 5; s++) begin
      drv();
      smp();
      check("t5_err", m_err_o, (s == 5) ? 3'b010 : 3'b000);
      check("t5_cyc_on", s_cyc_o, 1);
    end
    drv();
    smp();
    check("t5_flush_bus", {s_cyc_o, s_stb_o, s_we_o}, 0);
    check("t5_flush_gnt", gnt_o, 3'b010);
    check("t5_flush_err", m_err_o, 0);
    drv();
    smp();
    check("t5_flush_hold", {s_cyc_o, gnt_o}, 4'b0010);
    drv();
    set_m(1, 1'b0, 1'b0, 1'b0, 16'h4000, 16'h5555);
    smp();
    drv();
    smp();
    check("t5_idle", gnt_o, 0);

    // ack landing in the fifth cycle wins over the watchdog
    drv();
    set_m(1, 1'b1, 1'b1, 1'b1, 16'h4100, 16'h6666);
    exp_q.push_back(3'b010);
    smp();
    for (int s = 1; s <= 5; s++) begin
      drv();
      man_ack = (s == 5);
      smp();
      check("t5b_no_err", m_err_o, 0);
      check("t5b_ack", m_ack_o, (s == 5) ? 3'b010 : 3'b000);
    end
    drv();
    man_ack = 1'b0;
    smp();
    check("t5b_no_flush", s_cyc_o, 1);
    check("t5b_no_err_after", m_err_o, 0);
    drv();
    set_m(1, 1'b0, 1'b0, 1'b0, 16'h4100, 16'h6666);
    smp();
    drv();
    smp();
    check("t5b_idle", gnt_o, 0);

    // asynchronous reset in the middle of a granted strobe
    drv();
    set_m(1, 1'b1, 1'b1, 1'b0, 16'h6000, '0);
    man_ack = 1'b1;
    exp_q.push_back(3'b010);
    smp();
    drv();
    smp();
    check("t6_pre_ack", m_ack_o, 3'b010);
    check("t6_pre_stb", s_stb_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_gnt", gnt_o, 0);
    check("t6_async_bus", {s_cyc_o, s_stb_o}, 0);
    check("t6_async_ack", m_ack_o, 0);
    set_m(0, 1'b1, 1'b1, 1'b0, 16'h7000, '0);
    exp_q.push_back(3'b001);
    @(posedge clk);
    #1;
    rst = 1'b0;
    smp();
    check("t6_post_idle", gnt_o, 0);
    drv();
    smp();
    check("t6_m0_first", gnt_o, 3'b001);
    check("t6_m0_adr", s_adr_o, 16'h7000);
    drv();
    idle_all();
    man_ack = 1'b0;
    smp();
    drv();
    smp();
    check("t6_end_idle", gnt_o, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_rr.md
Name: wb_arbiter_rr

Overview:
Parametrised Wishbone classic arbiter. It connects N_MASTERS bus masters to one shared slave port using round-robin arbitration. A grant is held for the whole bus cycle (cyc), so multi-beat transfers stay locked to one master. A per-beat watchdog terminates stuck cycles with an error pulse. It sits between the J1 core, DMA-type masters and the peripheral/memory slave fabric.

Parameters:
N_MASTERS, 2, number of master ports (≥2).
ADR_WIDTH, 16, address width.
DAT_WIDTH, 16, data width.
TIMEOUT, 255, unacked-strobe wait cycles before error; 0 disables the watchdog.

Ports:
clk_i  in  1  clock, all state on rising edge.
rst_i  in  1  reset, asynchronous, active-high.
m_adr_i  in  N_MASTERS*ADR_WIDTH  master addresses; master k at slice k.
m_dat_i  in  N_MASTERS*DAT_WIDTH  master write data.
m_we_i  in  N_MASTERS  master write enables.
m_cyc_i  in  N_MASTERS  master cycle requests.
m_stb_i  in  N_MASTERS  master strobes.
m_dat_o  out  DAT_WIDTH  read data, broadcast to all masters.
m_ack_o  out  N_MASTERS  per-master acknowledge.
m_err_o  out  N_MASTERS  per-master timeout error.
s_adr_o  out  ADR_WIDTH  slave address.
s_dat_o  out  DAT_WIDTH  slave write data.
s_we_o  out  1  slave write enable.
s_cyc_o  out  1  slave cycle.
s_stb_o  out  1  slave strobe.
s_dat_i  in  DAT_WIDTH  slave read data.
s_ack_i  in  1  slave acknowledge.
gnt_o  out  N_MASTERS  registered one-hot grant; all zero when idle.

Behaviour:
- Reset (async, any time including mid-cycle):
  - state=IDLE, gnt_o=0, wait counter=0.
  - last-granted pointer = N_MASTERS-1, so master 0 has first priority.
  - All m_ack_o/m_err_o = 0; s_cyc_o, s_stb_o, s_we_o = 0; s_adr_o, s_dat_o = 0.
- States: IDLE, GRANT, FLUSH.
- IDLE:
  - Outputs as at reset.
  - If any m_cyc_i is high, pick the first requester searching from (last+1) mod N upward with wrap.
  - On the next edge: gnt_o gets that one-hot value, last gets that index, state goes to GRANT.
  - Arbitration latency is exactly 1 cycle from cyc to grant.
- GRANT (master g):
  - Combinational mux: s_adr_o/s_dat_o/s_we_o/s_stb_o come from master g; s_cyc_o = m_cyc_i[g].
  - m_ack_o[g] = s_ack_i; all other acks and errs are 0.
  - m_dat_o = s_dat_i at all times.
  - The grant is held while m_cyc_i[g]=1, regardless of other requests (bus lock).
  - When m_cyc_i[g]=0: go to IDLE on that edge; re-arbitration happens in IDLE the following cycle (1 idle cycle between owners).
  - Requests from other masters never preempt the owner.
- Watchdog (TIMEOUT>0):
  - Counter width is clog2(TIMEOUT+1).
  - In GRANT, the counter increments each cycle with s_stb_o=1 and s_ack_i=0; it clears on s_ack_i=1 or s_stb_o=0.
  - In a cycle with counter==TIMEOUT and s_ack_i=0: m_err_o[g]=1 (combinational, one cycle), counter clears, next state is FLUSH.
  - If ack arrives in the same cycle the counter reaches TIMEOUT, ack wins: no err.
- FLUSH:
  - Grant held; s_cyc_o=0, s_stb_o=0, s_we_o=0; ack/err = 0.
  - When m_cyc_i[g]=0, go to IDLE.
  - A master that ignores err stays locked until it drops cyc (documented master obligation).
- TIMEOUT=0: the counter is held at 0, err is never asserted, and FLUSH is unreachable.
- Requests presented while in GRANT or FLUSH are queued implicitly and served in round-robin order after release.
- A master that raises and drops cyc while not granted simply loses that request.

Test Plan:
1. N=2, master0 cyc/stb, write adr=0x1234 dat=0xBEEF; slave acks 2 cycles after stb → gnt_o=01 one cycle after cyc, s_adr_o=0x1234, s_we_o=1, m_ack_o=01 for exactly one cycle, master1 sees no ack.
2. Both masters raise cyc in the same cycle after reset, each single-beat with immediate ack → master0 granted first, then IDLE one cycle, then gnt_o=10; total order 0,1.
3. Master0 holds cyc for 3 acked read beats while master1 requests throughout → gnt_o stays 01 for all 3 beats; master1 granted only after master0 drops cyc; m_dat_o follows s_dat_i for each beat.
4. N=3, all three request continuously with single-beat cycles → grant sequence 0,1,2,0,1,2, no master starved.
5. TIMEOUT=4, master1 strobes and slave never acks → m_err_o=10 in the 5th strobe cycle, s_cyc_o=0 from the next cycle, IDLE once master1 drops cyc; repeat with ack landing in the 5th cycle → ack only, no err.
6. Assert rst_i asynchronously mid-GRANT with stb high → gnt_o, s_cyc_o, s_stb_o and m_ack_o go to 0 immediately; after release, master0 wins first arbitration.
